// File: rtl/vip_itc_handshake_pkg.sv
// Shared definitions for the control-to-video-clock mode handshake (RX and TX sides).
package vip_itc_handshake_pkg;

  // Receiver state encoding; the values are fixed so both sides can decode debug taps.
  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_SETTLE      = 2'd1,
    ST_WAIT_COMMIT = 2'd2
  } hs_state_t;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // The transmitter serialises debug/bus views MSB first; both sides map bit indices the same way.
  localparam bit TX_MSB_FIRST = 1'b1;

  // Position of logical bit idx in the TX-side ordering of a width-bit word.
  function automatic int tx_bit_pos(input int idx, input int width);
    return TX_MSB_FIRST ? (width - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/vip_itc_stability_counter.sv
// Bus stability tracker: compares the live synchronized bus against the held sample,
// counts consecutive equal samples and total settle cycles, both saturating.
module vip_itc_stability_counter
  import vip_itc_handshake_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             sync_clock,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic [WIDTH-1:0] data_sync,
  input  logic [WIDTH-1:0] hold,
  output logic             stable_done,
  output logic             timeout
);

  localparam int CW = clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(TIMEOUT_CYCLES - 1);

  logic          match;
  logic [CW-1:0] stable_cnt_reg;
  logic [CW-1:0] tmo_cnt_reg;

  assign match       = (data_sync == hold);
  assign stable_done = match && (stable_cnt_reg == STABLE_LAST);
  assign timeout     = (tmo_cnt_reg == TMO_LAST);

  // Counters restart on load and advance only while the FSM is settling.
  always_ff @(posedge sync_clock) begin
    if (!rst_n) begin
      stable_cnt_reg <= '0;
      tmo_cnt_reg    <= '0;
    end else if (load) begin
      stable_cnt_reg <= '0;
      tmo_cnt_reg    <= '0;
    end else if (run) begin
      if (!match) begin
        stable_cnt_reg <= '0;
      end else if (stable_cnt_reg != STABLE_LAST) begin
        stable_cnt_reg <= stable_cnt_reg + CW'(1);
      end
      if (tmo_cnt_reg != TMO_LAST) begin
        tmo_cnt_reg <= tmo_cnt_reg + CW'(1);
      end
    end
  end

endmodule

// File: rtl/vip_itc_mode_handshake_rx.sv
// Receive side of the mode handshake: detects request toggles, waits for the
// synchronized bus to settle and for a safe commit point, then commits the word,
// pulses update and flips the ack toggle back to the sender.
module vip_itc_mode_handshake_rx
  import vip_itc_handshake_pkg::*;
#(
  parameter int               WIDTH          = 32,
  parameter int               STABLE_CYCLES  = 4,
  parameter int               TIMEOUT_CYCLES = 1024,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic             sync_clock,
  input  logic             rst_n,
  input  logic             req_sync,
  input  logic [WIDTH-1:0] data_sync,
  input  logic             commit_ok,
  input  logic             err_clear,
  output logic [WIDTH-1:0] data_out,
  output logic             update,
  output logic             ack_toggle,
  output logic             busy,
  output logic             err_overrun,
  output logic             err_unstable
);

  hs_state_t        state_reg;
  hs_state_t        state_next;
  logic             req_d_reg;
  logic             req_edge;
  logic             pending_reg;
  logic [WIDTH-1:0] hold_reg;
  logic             load;
  logic             run;
  logic             commit;
  logic             set_unstable;
  logic             set_overrun;
  logic             stable_done;
  logic             timeout;

  assign req_edge    = req_sync ^ req_d_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign set_overrun = req_edge && busy;

  vip_itc_stability_counter #(
    .WIDTH          (WIDTH),
    .STABLE_CYCLES  (STABLE_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_stability (
    .sync_clock  (sync_clock),
    .rst_n       (rst_n),
    .load        (load),
    .run         (run),
    .data_sync   (data_sync),
    .hold        (hold_reg),
    .stable_done (stable_done),
    .timeout     (timeout)
  );

  // Next-state and control decode. An edge coinciding with a commit counts as queued work.
  always_comb begin
    state_next   = state_reg;
    load         = 1'b0;
    run          = 1'b0;
    commit       = 1'b0;
    set_unstable = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req_edge) begin
          state_next = ST_SETTLE;
          load       = 1'b1;
        end
      end
      ST_SETTLE: begin
        run = 1'b1;
        if (stable_done || timeout) begin
          state_next   = ST_WAIT_COMMIT;
          set_unstable = timeout && !stable_done;
        end
      end
      ST_WAIT_COMMIT: begin
        if (commit_ok) begin
          commit = 1'b1;
          if (pending_reg || req_edge) begin
            state_next = ST_SETTLE;
            load       = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge sync_clock) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Previous request level for toggle-edge detection.
  always_ff @(posedge sync_clock) begin
    if (!rst_n) begin
      req_d_reg <= 1'b0;
    end else begin
      req_d_reg <= req_sync;
    end
  end

  // Held bus sample: tracks the bus while settling, frozen while waiting to commit.
  always_ff @(posedge sync_clock) begin
    if (!rst_n) begin
      hold_reg <= '0;
    end else if (load || run) begin
      hold_reg <= data_sync;
    end
  end

  // Single-entry request queue; a commit consumes the queued request.
  always_ff @(posedge sync_clock) begin
    if (!rst_n) begin
      pending_reg <= 1'b0;
    end else if (commit) begin
      pending_reg <= pending_reg && req_edge;
    end else if (set_overrun) begin
      pending_reg <= 1'b1;
    end
  end

  // Committed word, update strobe and ack toggle all change on the commit edge only.
  always_ff @(posedge sync_clock) begin
    if (!rst_n) begin
      data_out   <= RESET_VALUE;
      update     <= 1'b0;
      ack_toggle <= 1'b0;
    end else begin
      update <= commit;
      if (commit) begin
        data_out   <= hold_reg;
        ack_toggle <= ~ack_toggle;
      end
    end
  end

  // Sticky error flags; a new error wins over a same-cycle clear.
  always_ff @(posedge sync_clock) begin
    if (!rst_n) begin
      err_overrun  <= 1'b0;
      err_unstable <= 1'b0;
    end else begin
      if (set_overrun) begin
        err_overrun <= 1'b1;
      end else if (err_clear) begin
        err_overrun <= 1'b0;
      end
      if (set_unstable) begin
        err_unstable <= 1'b1;
      end else if (err_clear) begin
        err_unstable <= 1'b0;
      end
    end
  end

endmodule
